rr_plogb_gearbox: RTL and testbench

//  Consumes the packed logging record from the logb merge tree (variable-length

---
 rtl/rr_plogb_gearbox_pkg.sv | 30 +++
 rtl/rr_bit_accumulator.sv | 64 ++++++
 rtl/rr_plogb_gearbox.sv | 119 +++++++++++
 tb/tb_rr_plogb_gearbox.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_plogb_gearbox_pkg.sv
// Shared types and helpers for the logb trace gearbox.
// Holds the gearbox state enum, default parameters and the header/record
// width derivations used by the top and the bit accumulator.
package rr_plogb_gearbox_pkg;

  localparam int DEF_FULL_WIDTH = 256;
  localparam int DEF_LOGB_CNT   = 8;
  localparam int DEF_LOGE_CNT   = 4;
  localparam int DEF_OUT_WIDTH  = 512;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PAD   = 2'd2,
    ST_DONE  = 2'd3
  } gearbox_state_e;

  // Header is the logb valid bits followed by the loge valid bits.
  function automatic int hdr_width(input int logb_cnt, input int loge_cnt);
    return logb_cnt + loge_cnt;
  endfunction

  // Largest record: full header plus a maximum-length payload.
  function automatic int rec_max_width(input int full_width, input int logb_cnt,
                                       input int loge_cnt);
    return hdr_width(logb_cnt, loge_cnt) + full_width;
  endfunction

endpackage

// File: rtl/rr_bit_accumulator.sv
// Purpose: dense bit accumulator; inserts a variable-length record at the fill
//   offset and pops fixed OUT_WIDTH beats from the LSB end.
// Latency: push/pop take effect on the next clock edge; beat_o is registered.
// Backpressure: none internally; the caller only pushes when there is room.
// Ports: clk/rstn (sync active-low), push_i/pop_i/clear_i commands, rec_i and
//   rec_len_i record to insert, beat_o low OUT_WIDTH bits, fill_o bit count.
module rr_bit_accumulator #(
  parameter int OUT_WIDTH = 512,
  parameter int REC_MAX   = 268,
  parameter int FILL_W    = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 clear_i,
  input  logic [REC_MAX-1:0]   rec_i,
  input  logic [FILL_W-1:0]    rec_len_i,
  output logic [OUT_WIDTH-1:0] beat_o,
  output logic [FILL_W-1:0]    fill_o
);

  localparam int ACC_W = OUT_WIDTH + REC_MAX;
  localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(ACC_W);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_base;
  logic [FILL_W-1:0] fill_q, fill_d, fill_base;

  always_comb begin
    // Pop first, so a same-cycle push lands at the post-pop offset.
    acc_base  = pop_i ? (acc_q >> OUT_WIDTH) : acc_q;
    fill_base = pop_i ? (fill_q - OUT_W_F) : fill_q;
    acc_d     = acc_base;
    fill_d    = fill_base;
    if (push_i) begin
      // rec_i arrives with bits above its length already zero, so OR-ing
      // keeps every bit above the new fill at zero.
      acc_d  = acc_base | ({{OUT_WIDTH{1'b0}}, rec_i} << fill_base);
      fill_d = fill_base + rec_len_i;
    end
    // Clear covers popping a padded beat, where fill is below OUT_WIDTH.
    if (clear_i) begin
      acc_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign beat_o = acc_q[OUT_WIDTH-1:0];
  assign fill_o = fill_q;

  a_fill_bound: assert property (@(posedge clk) disable iff (!rstn) fill_q <= FILL_MAX);

endmodule

// File: rtl/rr_plogb_gearbox.sv
// Purpose: repacks variable-length logb/loge records into dense OUT_WIDTH beats
//   for the trace DMA writer; flush drains and zero-pads the last partial beat.
// Latency: a completed beat is valid the cycle after the push that fills it.
// Backpressure: in_ready drops when a full beat is stalled or while flushing;
//   out_data/out_valid hold while out_valid && !out_ready.
// Ports: clk/rstn (sync active-low); in_* record handshake; out_* beat
//   handshake; flush_req/flush_done flush control; beat_cnt popped-beat count.
module rr_plogb_gearbox
  import rr_plogb_gearbox_pkg::*;
#(
  parameter int FULL_WIDTH = DEF_FULL_WIDTH,
  parameter int LOGB_CNT   = DEF_LOGB_CNT,
  parameter int LOGE_CNT   = DEF_LOGE_CNT,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int HDR_W     = hdr_width(LOGB_CNT, LOGE_CNT),
  localparam int REC_MAX   = rec_max_width(FULL_WIDTH, LOGB_CNT, LOGE_CNT),
  localparam int LEN_W     = $clog2(FULL_WIDTH + 1),
  localparam int FILL_W    = $clog2(OUT_WIDTH + REC_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [LOGB_CNT-1:0]   in_logb_v,
  input  logic [LOGE_CNT-1:0]   in_loge_v,
  input  logic [FULL_WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0]      in_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_WIDTH);
  localparam logic [FILL_W-1:0] HDR_W_F = FILL_W'(HDR_W);

  gearbox_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [FILL_W-1:0]     fill;
  logic [FULL_WIDTH-1:0] len_mask;
  logic [REC_MAX-1:0]    rec;
  logic [FILL_W-1:0]     rec_len;
  logic                  push, pop, clear;

  // Payload bits at or above in_len are forced to zero; in_len==FULL_WIDTH
  // shifts every one out, leaving an all-ones mask.
  assign len_mask = ~({FULL_WIDTH{1'b1}} << in_len);
  assign rec      = {in_data & len_mask, in_loge_v, in_logb_v};
  assign rec_len  = HDR_W_F + {{(FILL_W-LEN_W){1'b0}}, in_len};

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = (fill >= OUT_W_F);
    flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = (fill < OUT_W_F) || out_ready;
        if (flush_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // While a full beat remains, out_valid is already set by fill.
        if (fill == '0)          state_d = ST_DONE;
        else if (fill < OUT_W_F) state_d = ST_PAD;
      end
      ST_PAD: begin
        // Bits above fill are zero, so the low beat is already padded.
        out_valid = 1'b1;
        if (out_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  assign clear = pop && (state_q == ST_PAD);

  assign beat_cnt_d = pop ? (beat_cnt_q + CNT_WIDTH'(1)) : beat_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  rr_bit_accumulator #(
    .OUT_WIDTH(OUT_WIDTH),
    .REC_MAX  (REC_MAX),
    .FILL_W   (FILL_W)
  ) u_acc (
    .clk      (clk),
    .rstn     (rstn),
    .push_i   (push),
    .pop_i    (pop),
    .clear_i  (clear),
    .rec_i    (rec),
    .rec_len_i(rec_len),
    .beat_o   (out_data),
    .fill_o   (fill)
  );

  assign beat_cnt = beat_cnt_q;

  a_len_legal: assert property (@(posedge clk) disable iff (!rstn)
                                in_valid |-> (in_len <= LEN_W'(FULL_WIDTH)));

endmodule

// File: tb/tb_rr_plogb_gearbox.sv
module tb_rr_plogb_gearbox;

  logic         clk = 1'b0;
  logic         rstn;
  logic [7:0]   in_logb_v;
  logic [3:0]   in_loge_v;
  logic [255:0] in_data;
  logic [8:0]   in_len;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         flush_req;
  logic         flush_done;
  logic [31:0]  beat_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  rr_plogb_gearbox dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_logb_v (in_logb_v),
    .in_loge_v (in_loge_v),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush_req (flush_req),
    .flush_done(flush_done),
    .beat_cnt  (beat_cnt)
  );

  // Record as it should appear in the bit stream: header LSB first, payload
  // truncated to len bits.
  function automatic logic [267:0] mk_rec(input logic [7:0] b, input logic [3:0] e,
                                          input logic [255:0] d, input int len);
    logic [255:0] m;
    m = d;
    for (int i = len; i < 256; i++) m[i] = 1'b0;
    return {m, e, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    in_valid  = 1'b0;
    in_logb_v = '0;
    in_loge_v = '0;
    in_data   = '0;
    in_len    = '0;
  endtask

  task automatic drive_rec(input logic [7:0] b, input logic [3:0] e,
                           input logic [255:0] d, input int len);
    in_logb_v = b;
    in_loge_v = e;
    in_data   = d;
    in_len    = 9'(len);
    in_valid  = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; out_ready = 1'b1; flush_req = 1'b0; idle_in();
    repeat (3) tick();
    rstn = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (beat_cnt !== 32'd0) begin failures++; $display("FAIL reset_beat_cnt got=%0d want=0", beat_cnt); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done got=%b want=0", flush_done); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (dut.u_acc.fill_q !== 10'd0) begin failures++; $display("FAIL reset_fill got=%0d want=0", dut.u_acc.fill_q); end
  endtask

  task automatic test_two_records;
    logic [267:0] r0, r1;
    logic [511:0] exp;
    r0 = mk_rec(8'hA5, 4'h3, {8{32'hDEADBEEF}}, 244);
    r1 = mk_rec(8'h5A, 4'hC, {8{32'h12345678}}, 244);
    exp = {r1[255:0], r0[255:0]};
    drive_rec(8'hA5, 4'h3, {8{32'hDEADBEEF}}, 244);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL two_in_ready got=%b want=1", in_ready); end
    tick();
    checks++; if (dut.u_acc.fill_q !== 10'd256) begin failures++; $display("FAIL two_fill_256 got=%0d want=256", dut.u_acc.fill_q); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL two_out_valid_early got=%b want=0", out_valid); end
    drive_rec(8'h5A, 4'hC, {8{32'h12345678}}, 244);
    tick();
    idle_in();
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL two_out_valid got=%b want=1", out_valid); end
    checks++; if (out_data !== exp) begin failures++; $display("FAIL two_beat got=%h want=%h", out_data, exp); end
    checks++; if (dut.u_acc.fill_q !== 10'd512) begin failures++; $display("FAIL two_fill_512 got=%0d want=512", dut.u_acc.fill_q); end
    tick();
    exp_cnt++;
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL two_beat_cnt got=%0d want=%0d", beat_cnt, exp_cnt); end
    checks++; if (dut.u_acc.fill_q !== 10'd0) begin failures++; $display("FAIL two_fill_0 got=%0d want=0", dut.u_acc.fill_q); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL two_out_valid_after got=%b want=0", out_valid); end
  endtask

  // Leaves fill=88 holding the top of rec2 for test_flush_partial.
  logic [267:0] bb_r2;

  task automatic test_back_to_back;
    logic [267:0] r0, r1;
    logic [511:0] exp;
    r0    = mk_rec(8'h01, 4'h1, {8{32'hCAFEF00D}}, 188);
    r1    = mk_rec(8'h02, 4'h2, {8{32'h0F0F0F0F}}, 188);
    bb_r2 = mk_rec(8'h03, 4'h4, {8{32'h89ABCDEF}}, 188);
    exp = {bb_r2[111:0], r1[199:0], r0[199:0]};
    drive_rec(8'h01, 4'h1, {8{32'hCAFEF00D}}, 188); tick();
    drive_rec(8'h02, 4'h2, {8{32'h0F0F0F0F}}, 188); tick();
    checks++; if (dut.u_acc.fill_q !== 10'd400) begin failures++; $display("FAIL b2b_fill_400 got=%0d want=400", dut.u_acc.fill_q); end
    drive_rec(8'h03, 4'h4, {8{32'h89ABCDEF}}, 188); tick();
    idle_in();
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid got=%b want=1", out_valid); end
    checks++; if (out_data !== exp) begin failures++; $display("FAIL b2b_beat got=%h want=%h", out_data, exp); end
    tick();
    exp_cnt++;
    checks++; if (dut.u_acc.fill_q !== 10'd88) begin failures++; $display("FAIL b2b_fill_88 got=%0d want=88", dut.u_acc.fill_q); end
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL b2b_beat_cnt got=%0d want=%0d", beat_cnt, exp_cnt); end
  endtask

  task automatic test_flush_partial;
    logic [267:0] r3;
    logic [511:0] exp;
    // Zero-length payload: header only, 12 bits, brings fill from 88 to 100.
    r3  = mk_rec(8'h81, 4'h6, {256{1'b1}}, 0);
    exp = {412'd0, r3[11:0], bb_r2[199:112]};
    drive_rec(8'h81, 4'h6, {256{1'b1}}, 0); tick();
    idle_in();
    #1;
    checks++; if (dut.u_acc.fill_q !== 10'd100) begin failures++; $display("FAIL fp_fill_100 got=%0d want=100", dut.u_acc.fill_q); end
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fp_drain_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fp_drain_out_valid got=%b want=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fp_pad_out_valid got=%b want=1", out_valid); end
    checks++; if (out_data !== exp) begin failures++; $display("FAIL fp_pad_beat got=%h want=%h", out_data, exp); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fp_pad_flush_done got=%b want=0", flush_done); end
    tick();
    exp_cnt++;
    checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL fp_done_pulse got=%b want=1", flush_done); end
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL fp_beat_cnt got=%0d want=%0d", beat_cnt, exp_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fp_done_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fp_done_in_ready got=%b want=0", in_ready); end
    tick();
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fp_done_single got=%b want=0", flush_done); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fp_in_ready_back got=%b want=1", in_ready); end
    checks++; if (dut.u_acc.fill_q !== 10'd0) begin failures++; $display("FAIL fp_fill_0 got=%0d want=0", dut.u_acc.fill_q); end
  endtask

  task automatic test_flush_empty;
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fe_drain_out_valid got=%b want=0", out_valid); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fe_drain_flush_done got=%b want=0", flush_done); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fe_drain_in_ready got=%b want=0", in_ready); end
    tick();
    checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL fe_done_pulse got=%b want=1", flush_done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fe_no_beat got=%b want=0", out_valid); end
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL fe_beat_cnt got=%0d want=%0d", beat_cnt, exp_cnt); end
    // A request while in DONE is ignored: no second flush follows.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fe_run_in_ready got=%b want=1", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fe_ignored_req_in_ready got=%b want=1", in_ready); end
    tick();
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL fe_ignored_req_done got=%b want=0", flush_done); end
  endtask

  task automatic test_backpressure;
    logic [267:0] r0, r1, r2, r3;
    logic [511:0] exp, exp2;
    r0 = mk_rec(8'hF0, 4'h9, {8{32'h13579BDF}}, 244);
    r1 = mk_rec(8'h0F, 4'h5, {8{32'h2468ACE0}}, 244);
    r2 = mk_rec(8'h77, 4'hA, {8{32'hA5A55A5A}}, 244);
    r3 = mk_rec(8'h11, 4'h7, {8{32'h600DC0DE}}, 244);
    exp  = {r1[255:0], r0[255:0]};
    exp2 = {r3[255:0], r2[255:0]};
    out_ready = 1'b0;
    drive_rec(8'hF0, 4'h9, {8{32'h13579BDF}}, 244); tick();
    drive_rec(8'h0F, 4'h5, {8{32'h2468ACE0}}, 244); tick();
    drive_rec(8'h77, 4'hA, {8{32'hA5A55A5A}}, 244);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%b want=0", in_ready); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin failures++; $display("FAIL bp_hold_%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready_%0d got=%b want=0", i, in_ready); end
    end
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL bp_cnt_stalled got=%0d want=%0d", beat_cnt, exp_cnt); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    tick();
    exp_cnt++;
    idle_in();
    #1;
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL bp_cnt_release got=%0d want=%0d", beat_cnt, exp_cnt); end
    checks++; if (dut.u_acc.fill_q !== 10'd256) begin failures++; $display("FAIL bp_fill_256 got=%0d want=256", dut.u_acc.fill_q); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_out_valid_mid got=%b want=0", out_valid); end
    drive_rec(8'h11, 4'h7, {8{32'h600DC0DE}}, 244); tick();
    idle_in();
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== exp2) begin failures++; $display("FAIL bp_second_beat got=%b/%h want=1/%h", out_valid, out_data, exp2); end
    tick();
    exp_cnt++;
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL bp_cnt_final got=%0d want=%0d", beat_cnt, exp_cnt); end
  endtask

  task automatic test_reset_in_pad;
    drive_rec(8'hC3, 4'hB, {8{32'hFFFFFFFF}}, 88); tick();
    idle_in();
    out_ready = 1'b0;
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rp_pad_valid got=%b want=1", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rp_pad_hold got=%b want=1", out_valid); end
    rstn = 1'b0; tick(); rstn = 1'b1;
    exp_cnt = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rp_out_valid got=%b want=0", out_valid); end
    checks++; if (dut.u_acc.fill_q !== 10'd0) begin failures++; $display("FAIL rp_fill got=%0d want=0", dut.u_acc.fill_q); end
    checks++; if (beat_cnt !== 32'(exp_cnt)) begin failures++; $display("FAIL rp_beat_cnt got=%0d want=0", beat_cnt); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rp_flush_done got=%b want=0", flush_done); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rp_in_ready got=%b want=1", in_ready); end
    tick();
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL rp_no_done_later got=%b want=0", flush_done); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rp_out_valid_later got=%b want=0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_records();
    test_back_to_back();
    test_flush_partial();
    test_flush_empty();
    test_backpressure();
    test_reset_in_pad();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
